// File: rtl/light_com_pkg.sv
// Shared constants and FSM state type for the light centre-of-mass block.
package com_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int SUM_W    = 32;
  localparam int CNT_W    = 20;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVIDE  = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

endpackage : com_pkg

// File: rtl/light_com_if.sv
// Pixel stream in, centroid result out. The pixel source is the master.
interface light_com_if;
  import com_pkg::*;

  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic           valid_in;
  logic           tabulate_in;
  logic           new_com;
  logic           light_on;
  logic [X_W-1:0] x_com;
  logic [Y_W-1:0] y_com;

  modport master (
    output x_in, y_in, valid_in, tabulate_in,
    input  new_com, light_on, x_com, y_com
  );

  modport slave (
    input  x_in, y_in, valid_in, tabulate_in,
    output new_com, light_on, x_com, y_com
  );

endinterface : light_com_if

// File: rtl/light_com_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first
// iteration runs on the start cycle itself, so valid_out pulses exactly
// WIDTH cycles after start. A zero divisor yields an all-ones quotient.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             valid_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   rem_in;
  logic [WIDTH-1:0] quo_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One restoring step: operands come fresh on start, otherwise from state.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (start) begin
      rem_in = '0;
      quo_in = dividend;
      dvs_d  = divisor;
    end else begin
      rem_in = rem_q;
      quo_in = quo_q;
    end
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_d};
    if (start || busy_q) begin
      if (!trial[WIDTH]) begin
        rem_d = trial;
        quo_d = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted;
        quo_d = {quo_in[WIDTH-2:0], 1'b0};
      end
      if (start) begin
        cnt_d  = CW'(WIDTH - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
    end
  end

  // Divider state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = quo_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;

endmodule : divider

// File: rtl/light_com.sv
// Centre of mass of lit pixels: accumulate per frame, snapshot on the
// frame-end pulse, divide both sums by the count, publish once per frame.
module light_com
  import com_pkg::*;
#(
  parameter int MIN_PIXELS = 16
) (
  input logic        clk_in,
  input logic        rst_in,
  light_com_if.slave bus
);
  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, snap_cnt_q;
  logic [SUM_W-1:0] sum_x_q, sum_y_q, snap_x_q, snap_y_q;
  logic             start_q;
  logic             light_q;
  logic [X_W-1:0]   x_com_q;
  logic [Y_W-1:0]   y_com_q;

  logic [CNT_W-1:0] pix_cnt;
  logic [SUM_W-1:0] pix_x, pix_y;
  logic [SUM_W-1:0] quo_x, quo_y;
  logic             vx, vy, bx, by;
  logic             div_done, publish_ok;
  logic             unused_bits;

  assign pix_cnt    = bus.valid_in ? CNT_W'(1) : '0;
  assign pix_x      = bus.valid_in ? SUM_W'(bus.x_in) : '0;
  assign pix_y      = bus.valid_in ? SUM_W'(bus.y_in) : '0;
  assign div_done   = vx & vy;
  assign publish_ok = snap_cnt_q >= CNT_W'(MIN_PIXELS);

  // Centroids are bounded by the frame size, so the upper quotient bits
  // and the busy flags carry no information here.
  assign unused_bits = ^{bx, by, quo_x[SUM_W-1:X_W], quo_y[SUM_W-1:Y_W]};

  // Next-state: accept a frame end only when idle, publish when both divides finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.tabulate_in) state_d = ST_DIVIDE;
      ST_DIVIDE:  if (div_done)        state_d = ST_PUBLISH;
      ST_PUBLISH:                      state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Accumulate lit pixels; a frame end always clears, but only snapshots when idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      snap_cnt_q <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      start_q    <= 1'b0;
    end else begin
      start_q <= bus.tabulate_in && (state_q == ST_IDLE);
      if (bus.tabulate_in) begin
        cnt_q   <= '0;
        sum_x_q <= '0;
        sum_y_q <= '0;
        if (state_q == ST_IDLE) begin
          snap_cnt_q <= cnt_q + pix_cnt;
          snap_x_q   <= sum_x_q + pix_x;
          snap_y_q   <= sum_y_q + pix_y;
        end
      end else begin
        cnt_q   <= cnt_q + pix_cnt;
        sum_x_q <= sum_x_q + pix_x;
        sum_y_q <= sum_y_q + pix_y;
      end
    end
  end

  // Result registers change only on the cycle the divides complete.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      light_q <= 1'b0;
      x_com_q <= '0;
      y_com_q <= '0;
    end else if (state_q == ST_DIVIDE && div_done) begin
      light_q <= publish_ok;
      if (publish_ok) begin
        x_com_q <= quo_x[X_W-1:0];
        y_com_q <= quo_y[Y_W-1:0];
      end
    end
  end

  divider #(.WIDTH(SUM_W)) u_div_x (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start_q),
    .dividend  (snap_x_q),
    .divisor   (SUM_W'(snap_cnt_q)),
    .quotient  (quo_x),
    .valid_out (vx),
    .busy      (bx)
  );

  divider #(.WIDTH(SUM_W)) u_div_y (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start_q),
    .dividend  (snap_y_q),
    .divisor   (SUM_W'(snap_cnt_q)),
    .quotient  (quo_y),
    .valid_out (vy),
    .busy      (by)
  );

  assign bus.new_com  = (state_q == ST_PUBLISH);
  assign bus.light_on = light_q;
  assign bus.x_com    = x_com_q;
  assign bus.y_com    = y_com_q;

endmodule : light_com

// File: tb/tb_light_com.sv
// Bench for light_com: frame table, hand-written corner sequences and
// random frames, all checked every cycle against a frame-level model.
module tb_light_com;
  import com_pkg::*;

  localparam int MINP = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  light_com_if bus_if();

  light_com #(.MIN_PIXELS(MINP)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulses = 0;

  // Frame-level reference model
  longint m_cnt, m_sx, m_sy;
  longint s_cnt, s_sx, s_sy;
  int     last_acc = -1000;
  int     pub_cyc  = 0;
  bit     pending  = 0;
  bit     e_new = 0, e_light = 0;
  int     e_x = 0, e_y = 0;

  typedef struct {
    int x; int y; int n;
    int ex; int ey; bit el;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("new_com",  32'(bus_if.new_com),  32'(e_new));
    check("light_on", 32'(bus_if.light_on), 32'(e_light));
    check("x_com",    32'(bus_if.x_com),    32'(e_x));
    check("y_com",    32'(bus_if.y_com),    32'(e_y));
  endtask

  // Drive one cycle of input, advance the model, then compare all outputs.
  task automatic step(input bit v, input int x, input int y, input bit tab);
    bus_if.valid_in    = v;
    bus_if.x_in        = 11'(x);
    bus_if.y_in        = 10'(y);
    bus_if.tabulate_in = tab;
    if (tab) begin
      if (cyc - last_acc >= 35) begin
        s_cnt    = m_cnt + (v ? 1 : 0);
        s_sx     = m_sx + (v ? x : 0);
        s_sy     = m_sy + (v ? y : 0);
        pending  = 1;
        pub_cyc  = cyc + 34;
        last_acc = cyc;
      end
      m_cnt = 0; m_sx = 0; m_sy = 0;
    end else if (v) begin
      m_cnt += 1; m_sx += x; m_sy += y;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_new = 0;
    if (pending && cyc == pub_cyc) begin
      e_new   = 1;
      pending = 0;
      if (s_cnt >= MINP) begin
        e_light = 1;
        e_x     = int'(s_sx / s_cnt);
        e_y     = int'(s_sy / s_cnt);
      end else begin
        e_light = 0;
      end
      $display("publish cyc=%0d count=%0d light=%0d x=%0d y=%0d", cyc, s_cnt, e_light, e_x, e_y);
    end
    if (bus_if.new_com === 1'b1) pulses++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset(input int ncyc);
    bus_if.valid_in    = 0;
    bus_if.tabulate_in = 0;
    rst = 1'b1;
    #1;
    e_new = 0; e_light = 0; e_x = 0; e_y = 0;
    pending = 0; last_acc = -1000;
    m_cnt = 0; m_sx = 0; m_sy = 0;
    check_outputs();
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_outputs();
    end
    rst = 1'b0;
  endtask

  initial begin
    int t0, p0, n, gap;
    m_cnt = 0; m_sx = 0; m_sy = 0;
    s_cnt = 0; s_sx = 0; s_sy = 0;
    bus_if.x_in = '0; bus_if.y_in = '0;
    bus_if.valid_in = 0; bus_if.tabulate_in = 0;

    tbl[0] = '{x: 100,  y: 50,  n: 16, ex: 100,  ey: 50,  el: 1'b1};
    tbl[1] = '{x: 0,    y: 0,   n: 16, ex: 0,    ey: 0,   el: 1'b1};
    tbl[2] = '{x: 1279, y: 719, n: 20, ex: 1279, ey: 719, el: 1'b1};
    tbl[3] = '{x: 640,  y: 360, n: 16, ex: 640,  ey: 360, el: 1'b1};
    tbl[4] = '{x: 5,    y: 5,   n: 15, ex: 640,  ey: 360, el: 1'b0};
    tbl[5] = '{x: 7,    y: 7,   n: 0,  ex: 640,  ey: 360, el: 1'b0};

    @(negedge clk);
    do_reset(3);
    idle(2);

    // Single-point frames from the table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(1, tbl[i].x, tbl[i].y, 0);
      t0 = cyc;
      step(0, 0, 0, 1);
      while (cyc < t0 + 33) step(0, 0, 0, 0);
      check("tbl_pre_new", 32'(bus_if.new_com), 32'd0);
      step(0, 0, 0, 0);
      check("tbl_new",   32'(bus_if.new_com),  32'd1);
      check("tbl_light", 32'(bus_if.light_on), 32'(tbl[i].el));
      check("tbl_x",     32'(bus_if.x_com),    32'(tbl[i].ex));
      check("tbl_y",     32'(bus_if.y_com),    32'(tbl[i].ey));
      step(0, 0, 0, 0);
      check("tbl_new_low", 32'(bus_if.new_com), 32'd0);
      idle(1);
    end

    // Rectangle x 200..203, y 300..301 twice; last pixel shares the tabulate cycle
    for (int r = 0; r < 2; r++)
      for (int yy = 300; yy <= 301; yy++)
        for (int xx = 200; xx <= 203; xx++)
          step(1, xx, yy, (r == 1 && yy == 301 && xx == 203));
    t0 = cyc - 1;
    while (cyc < t0 + 34) step(0, 0, 0, 0);
    check("rect_new", 32'(bus_if.new_com), 32'd1);
    check("rect_x",   32'(bus_if.x_com),   32'd201);
    check("rect_y",   32'(bus_if.y_com),   32'd300);
    idle(3);

    // Second frame end while dividing: frame dropped, one pulse per accepted frame
    for (int k = 0; k < 16; k++) step(1, 10, 10, 0);
    p0 = pulses;
    t0 = cyc;
    step(0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) step(1, 900, 600, 0);
    step(1, 900, 600, 1);
    for (int k = 11; k <= 49; k++) step(1, 300 + (k % 3), 200, 0);
    step(1, 300, 200, 1);
    while (cyc < t0 + 50 + 36) step(0, 0, 0, 0);
    check("drop_pulses", 32'(pulses - p0), 32'd2);
    check("drop_x",      32'(bus_if.x_com), 32'd300);
    check("drop_y",      32'(bus_if.y_com), 32'd200);

    // Reset during division: no publish, then a clean frame publishes
    for (int k = 0; k < 16; k++) step(1, 50, 60, 0);
    p0 = pulses;
    t0 = cyc;
    step(0, 0, 0, 1);
    while (cyc < t0 + 20) step(0, 0, 0, 0);
    do_reset(2);
    while (cyc < t0 + 40) step(0, 0, 0, 0);
    check("rst_no_pulse", 32'(pulses - p0), 32'd0);
    for (int k = 0; k < 16; k++) step(1, 77, 88, 0);
    t0 = cyc;
    step(0, 0, 0, 1);
    while (cyc < t0 + 34) step(0, 0, 0, 0);
    check("rst_after_x", 32'(bus_if.x_com), 32'd77);
    check("rst_after_y", 32'(bus_if.y_com), 32'd88);
    idle(3);

    // Random frames with random gaps (short gaps exercise dropped frames)
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++)
        step(($urandom_range(0, 3) != 0), $urandom_range(0, H_ACTIVE - 1),
             $urandom_range(0, V_ACTIVE - 1), 0);
      step($urandom_range(0, 1), $urandom_range(0, H_ACTIVE - 1),
           $urandom_range(0, V_ACTIVE - 1), 1);
      gap = $urandom_range(5, 45);
      idle(gap);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_light_com
